skew_read_buf: RTL and testbench
================================

Name: skew_read_buf

Overview:
- Multi-channel, double-buffered operand buffer that feeds one edge of the systolic array.
- Holds DEPTH words per channel in each of two banks (ping-pong). Software/loader writes one bank while the other streams.
- On start, streams all CH channels in parallel with diagonal skew: channel c is delayed c cycles. Operands arrive at the array pre-staggered, and idle lanes are zero-padded.

Parameters:
- X_W, 9, data word width.
- DEPTH, 8, words per channel per bank (>=2).
- CH, 4, channel count = array rows/cols fed (>=1).
- Derived: LEN = DEPTH+CH-1 output cycles per stream. CW = max(1,$clog2(CH)). AW = $clog2(DEPTH). KW = $clog2(LEN).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- w_vi  in  1  write valid.
- w_ch_i  in  CW  write channel index.
- addr_w_i  in  AW  write word address.
- data_w_i  in  X_W  write data.
- swap_i  in  1  request read/write bank exchange.
- start_vi  in  1  request stream of read bank.
- ready_o  out  1  start/swap accepted this cycle.
- d_o  out  CH*X_W  lane c at bits [c*X_W +: X_W].
- v_vo  out  CH  per-lane valid.
- done_o  out  1  pulse on last output cycle of a stream.
- rd_bank_o  out  1  current read bank.

Behaviour:
- Reset (rst_i=0 at posedge): state=IDLE, cnt_r=0, rd_bank=0, d_o=0, v_vo=0, done_o=0. ready_o=1 combinationally after reset. Memory contents are not reset.
- Storage is mem[bank][ch][addr]. Writes always target bank ~rd_bank, using rd_bank sampled in the same cycle. A write and a swap in the same cycle lands in the pre-swap write bank, which becomes the new read bank.
- FSM states:
  - IDLE -> RUN when start_vi & ready_o.
  - RUN -> IDLE when cnt_r==LEN-1 and no start.
  - RUN -> RUN (cnt_r cleared to 0) when cnt_r==LEN-1 and start_vi: gapless back-to-back streams.
- ready_o = (state==IDLE) | (state==RUN & cnt_r==LEN-1).
- swap_i with ready_o=1 toggles rd_bank at the edge. swap_i with ready_o=0 is dropped (not queued).
- swap_i and start_vi in the same ready cycle: the new stream reads the post-swap bank.
- start_vi with ready_o=0 is dropped.
- Latency: start accepted at edge t, so the first output cycle is t+1 (k=0). Outputs are registered. cnt_r = k of the cycle currently presented.
- Lane c at stream cycle k:
  - v_vo[c] = (k>=c) & (k<c+DEPTH).
  - d_o lane c = mem[rd_bank][c][k-c] when valid, else 0.
  - Address arithmetic uses KW bits; no wrap across channels.
- done_o = 1 exactly when state==RUN and cnt_r==LEN-1.
- In IDLE: d_o=0, v_vo=0, done_o=0.
- Read/write collision: a write to the current read bank is impossible by construction.
- Writes during RUN never alter the active stream. Writing the same address twice in one stream keeps the last write.
- Reset mid-stream: at the next edge all outputs are 0, state=IDLE, rd_bank=0. The remainder of the stream is discarded.
- CH=1: no skew, LEN=DEPTH; behaviour otherwise identical.

Test Plan:
- Reset check: hold rst_i=0 for 2 cycles, then release. Required: d_o=0, v_vo=0, done_o=0, ready_o=1, rd_bank_o=0.
- Skew stream (CH=4, DEPTH=8):
  - Stimulus: write bank 1 with mem[c][a]=c*16+a, pulse swap_i, then start.
  - k=0: v_vo=0001, lane0=0x00.
  - k=3: v_vo=1111, lane0=0x03, lane3=0x30.
  - k=7: v_vo=1111, lane0=0x07, lane3=0x34.
  - k=8: v_vo=1110.
  - k=10: v_vo=1000, lane3=0x37, done_o=1, lanes 0-2 =0.
  - 11 output cycles total.
- Back-to-back: assert start_vi in the done_o cycle. Next cycle k=0 of the second stream (v_vo=0001, lane0=0x00), with no idle gap.
- Dropped requests: pulse start_vi and swap_i at k=4. Required: stream unaffected, rd_bank_o unchanged, single done_o at k=10.
- Ping-pong:
  - During a stream from bank 1, write 0xFF to all of bank 0. The stream data is unchanged.
  - Then assert swap+start in the same cycle. The new stream shows 0xFF on valid lanes, and rd_bank_o=0.
- Reset mid-stream: assert rst_i=0 at k=5. Next cycle v_vo=0, d_o=0, done_o never pulses, ready_o=1.

Source files
------------

// File: rtl/skew_read_buf.sv
// Ping-pong operand buffer that streams CH channels into the array with a diagonal skew.
// Lane c lags lane 0 by c cycles, and lanes are zero outside their DEPTH-word window.
module skew_read_buf #(
    parameter int X_W   = 9,
    parameter int DEPTH = 8,
    parameter int CH    = 4,
    localparam int LEN  = DEPTH + CH - 1,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int KW   = $clog2(LEN)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              w_vi,
    input  logic [CW-1:0]     w_ch_i,
    input  logic [AW-1:0]     addr_w_i,
    input  logic [X_W-1:0]    data_w_i,
    input  logic              swap_i,
    input  logic              start_vi,
    output logic              ready_o,
    output logic [CH*X_W-1:0] d_o,
    output logic [CH-1:0]     v_vo,
    output logic              done_o,
    output logic              rd_bank_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     cnt_q, cnt_d;
    logic              rd_bank_q, rd_bank_d;
    logic [CH*X_W-1:0] d_q, d_d;
    logic [CH-1:0]     v_q, v_d;
    logic              last;
    logic              ready;

    logic [X_W-1:0] mem_q [0:1][0:CH-1][0:DEPTH-1];

    // The write bank is always the one not being read, so a stream can never see a write.
    always_ff @(posedge clk_i) begin
        if (w_vi) begin
            mem_q[~rd_bank_q][w_ch_i][addr_w_i] <= data_w_i;
        end
    end

    always_comb begin
        last      = (cnt_q == KW'(LEN - 1));
        ready     = (state_q == S_IDLE) || ((state_q == S_RUN) && last);
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_bank_d = rd_bank_q ^ (swap_i & ready);
        case (state_q)
            S_IDLE: begin
                if (start_vi) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = start_vi ? S_RUN : S_IDLE;
                end else begin
                    cnt_d = cnt_q + KW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from next state so the first stream word appears one cycle after start.
    always_comb begin
        v_d = '0;
        d_d = '0;
        if (state_d == S_RUN) begin
            for (int c = 0; c < CH; c++) begin
                if ((int'(cnt_d) >= c) && (int'(cnt_d) < c + DEPTH)) begin
                    v_d[c]             = 1'b1;
                    d_d[c*X_W +: X_W]  = mem_q[rd_bank_d][c][AW'(cnt_d - KW'(c))];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_bank_q <= 1'b0;
            d_q       <= '0;
            v_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_bank_q <= rd_bank_d;
            d_q       <= d_d;
            v_q       <= v_d;
        end
    end

    assign ready_o   = ready;
    assign d_o       = d_q;
    assign v_vo      = v_q;
    assign done_o    = (state_q == S_RUN) && last;
    assign rd_bank_o = rd_bank_q;

endmodule

// File: tb/tb_skew_read_buf.sv
// Directed bench for skew_read_buf: reset, skewed stream, back-to-back, dropped requests,
// ping-pong isolation, and reset in the middle of a stream.
module tb_skew_read_buf;

    localparam int X_W = 9;
    localparam int DEPTH = 8;
    localparam int CH = 4;
    localparam int LEN = DEPTH + CH - 1;

    logic              clk;
    logic              rst_i;
    logic              w_vi;
    logic [1:0]        w_ch_i;
    logic [2:0]        addr_w_i;
    logic [X_W-1:0]    data_w_i;
    logic              swap_i;
    logic              start_vi;
    logic              ready_o;
    logic [CH*X_W-1:0] d_o;
    logic [CH-1:0]     v_vo;
    logic              done_o;
    logic              rd_bank_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    skew_read_buf #(.X_W(X_W), .DEPTH(DEPTH), .CH(CH)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .w_vi      (w_vi),
        .w_ch_i    (w_ch_i),
        .addr_w_i  (addr_w_i),
        .data_w_i  (data_w_i),
        .swap_i    (swap_i),
        .start_vi  (start_vi),
        .ready_o   (ready_o),
        .d_o       (d_o),
        .v_vo      (v_vo),
        .done_o    (done_o),
        .rd_bank_o (rd_bank_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [X_W-1:0] lane(input int c);
        return d_o[c*X_W +: X_W];
    endfunction

    // Expected lane value for the bank loaded with c*16+a.
    function automatic logic [X_W-1:0] ref_lane(input int c, input int k);
        if (k >= c && k < c + DEPTH) return X_W'(c*16 + (k - c));
        return '0;
    endfunction

    initial begin
        rst_i = 1'b0; w_vi = 1'b0; w_ch_i = '0; addr_w_i = '0; data_w_i = '0;
        swap_i = 1'b0; start_vi = 1'b0;

        step(); step();
        chk("rst_d", 64'(d_o), 64'h0);
        chk("rst_v", 64'(v_vo), 64'h0);
        chk("rst_done", 64'(done_o), 64'h0);
        chk("rst_ready", 64'(ready_o), 64'h1);
        chk("rst_bank", 64'(rd_bank_o), 64'h0);
        rst_i = 1'b1;
        step();

        // Load bank 1 (the write bank while rd_bank=0).
        for (int i = 0; i < CH*DEPTH; i++) begin
            w_vi = 1'b1; w_ch_i = 2'(i / DEPTH); addr_w_i = 3'(i % DEPTH);
            data_w_i = X_W'((i / DEPTH) * 16 + (i % DEPTH));
            step();
        end
        w_vi = 1'b0;
        swap_i = 1'b1;
        step();
        swap_i = 1'b0;
        chk("swap_bank", 64'(rd_bank_o), 64'h1);

        // Stream 1
        start_vi = 1'b1;
        step();
        start_vi = 1'b0;
        chk("s1_k0_v", 64'(v_vo), 64'h1);
        chk("s1_k0_l0", 64'(lane(0)), 64'h00);
        chk("s1_k0_ready", 64'(ready_o), 64'h0);
        step(); step(); step();
        chk("s1_k3_v", 64'(v_vo), 64'hF);
        chk("s1_k3_l0", 64'(lane(0)), 64'h03);
        chk("s1_k3_l3", 64'(lane(3)), 64'h30);
        step(); step(); step(); step();
        chk("s1_k7_v", 64'(v_vo), 64'hF);
        chk("s1_k7_l0", 64'(lane(0)), 64'h07);
        chk("s1_k7_l3", 64'(lane(3)), 64'h34);
        step();
        chk("s1_k8_v", 64'(v_vo), 64'hE);
        chk("s1_k8_l1", 64'(lane(1)), 64'h17);
        step(); step();
        chk("s1_k10_v", 64'(v_vo), 64'h8);
        chk("s1_k10_l3", 64'(lane(3)), 64'h37);
        chk("s1_k10_done", 64'(done_o), 64'h1);
        chk("s1_k10_lo", 64'(d_o[3*X_W-1:0]), 64'h0);
        chk("s1_k10_ready", 64'(ready_o), 64'h1);

        // Back-to-back stream 2, with dropped start/swap at k=4
        start_vi = 1'b1;
        step();
        start_vi = 1'b0;
        chk("s2_k0_v", 64'(v_vo), 64'h1);
        chk("s2_k0_l0", 64'(lane(0)), 64'h00);
        chk("s2_k0_done", 64'(done_o), 64'h0);
        n_done = 0;
        for (int k = 1; k < LEN; k++) begin
            if (k == 5) begin
                start_vi = 1'b1; swap_i = 1'b1;
            end
            step();
            start_vi = 1'b0; swap_i = 1'b0;
            if (done_o) n_done++;
            if (k == 5) begin
                chk("s2_k5_bank", 64'(rd_bank_o), 64'h1);
                chk("s2_k5_v", 64'(v_vo), 64'hF);
                chk("s2_k5_l1", 64'(lane(1)), 64'h14);
            end
        end
        chk("s2_k10_done", 64'(done_o), 64'h1);
        chk("s2_k10_l3", 64'(lane(3)), 64'h37);
        step();
        if (done_o) n_done++;
        chk("s2_done_count", 64'(n_done), 64'h1);
        chk("idle_v", 64'(v_vo), 64'h0);
        chk("idle_d", 64'(d_o), 64'h0);
        chk("idle_done", 64'(done_o), 64'h0);
        chk("idle_ready", 64'(ready_o), 64'h1);
        chk("idle_bank", 64'(rd_bank_o), 64'h1);

        // Stream 3 from bank 1 while bank 0 is overwritten with 0xFF
        start_vi = 1'b1;
        step();
        start_vi = 1'b0;
        for (int i = 0; i < CH*DEPTH; i++) begin
            if (i < LEN) begin
                chk($sformatf("pp_k%0d_v", i), 64'(v_vo),
                    64'({i < DEPTH + 3, i < DEPTH + 2 && i >= 2, i < DEPTH + 1 && i >= 1, i < DEPTH}
                        & {i >= 3, 1'b1, 1'b1, 1'b1}));
                for (int c = 0; c < CH; c++)
                    chk($sformatf("pp_k%0d_l%0d", i, c), 64'(lane(c)), 64'(ref_lane(c, i)));
            end
            w_vi = 1'b1; w_ch_i = 2'(i / DEPTH); addr_w_i = 3'(i % DEPTH); data_w_i = 9'h0FF;
            step();
        end
        w_vi = 1'b0;
        chk("pp_idle_ready", 64'(ready_o), 64'h1);

        // Swap and start together: new stream reads bank 0
        swap_i = 1'b1; start_vi = 1'b1;
        step();
        swap_i = 1'b0; start_vi = 1'b0;
        chk("s4_bank", 64'(rd_bank_o), 64'h0);
        chk("s4_k0_v", 64'(v_vo), 64'h1);
        chk("s4_k0_l0", 64'(lane(0)), 64'h0FF);
        step(); step(); step();
        chk("s4_k3_d", 64'(d_o), 64'({4{9'h0FF}}));
        step(); step();
        chk("s4_k5_v", 64'(v_vo), 64'hF);

        // Reset at k=5
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        chk("mid_rst_v", 64'(v_vo), 64'h0);
        chk("mid_rst_d", 64'(d_o), 64'h0);
        chk("mid_rst_done", 64'(done_o), 64'h0);
        chk("mid_rst_ready", 64'(ready_o), 64'h1);
        chk("mid_rst_bank", 64'(rd_bank_o), 64'h0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_o || v_vo != 0) n_done++;
        end
        chk("mid_rst_quiet", 64'(n_done), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
